rca_chunked_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor, the successor to the fixed 64-bit ripple-carry adder. It processes a WIDTH-bit operation CHUNK bits per clock through a single CHUNK-bit ripple-carry slice, with a registered inter-chunk carry. This trades latency for area and lets carry-chain length be set per instance. The block sits behind a valid/ready handshake on both input and output, so it drops into streaming datapaths.

---
 rtl/rca_chunked_adder.sv | 142 ++++++++++++++
 tb/tb_rca_chunked_adder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rca_chunked_adder.sv
// rca_chunked_adder
//
// Multi-cycle adder/subtractor. A WIDTH-bit operation is processed CHUNK bits
// per clock through one CHUNK-bit ripple-carry slice. The carry between chunks
// is held in a register. The block accepts one operation at a time, has no
// input buffering, and does not overlap operations.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and the payload stable until that edge.
// Ready never depends combinationally on valid. Here in_ready depends only on
// state. out_valid also depends only on state, and out_valid/sum/cout/ovf stay
// stable for as long as out_ready is low.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand bundle valid
//   in_ready   high only in IDLE
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in, ignored when sub=1
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result valid (DONE), held until out_ready
//   out_ready  downstream takes the result
//   sum        result modulo 2^WIDTH (bits are stale until out_valid)
//   cout       carry out of the MSB (for sub, 1 means no borrow)
//   ovf        signed overflow
//   busy       high in RUN or DONE
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
module rca_chunked_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("rca_chunked_adder: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;   // holds b already inverted for subtraction

  // The control outputs are decoded from the state register only.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // One CHUNK-bit ripple-carry slice operating on chunk k.
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cs;
  logic             c_msb_in;  // carry into the top bit of the slice
  logic             c_out;

  assign ca = a_r[k*CHUNK +: CHUNK];
  assign cb = b_r[k*CHUNK +: CHUNK];

  always_comb begin : ripple
    logic c;
    c        = carry;
    cs       = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb_in = c;
      cs[i] = ca[i] ^ cb[i] ^ c;
      c     = (ca[i] & cb[i]) | (c & (ca[i] ^ cb[i]));
    end
    c_out = c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b ^ {WIDTH{sub}};
            carry <= sub ? 1'b1 : cin;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[k*CHUNK +: CHUNK] <= cs;
          carry                 <= c_out;
          if (k == KLAST) begin
            // In the last chunk the slice MSB is the word MSB.
            cout  <= c_out;
            ovf   <= c_msb_in ^ c_out;
            state <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_chunked_adder.sv
// Testbench for rca_chunked_adder. Three instances share clk/rst:
// index 0 uses CHUNK=16 (latency 4), index 1 uses CHUNK=1 (latency 64),
// and index 2 uses CHUNK=64 (latency 1). Expected results come from an
// arithmetic reference model or from fixed constants. They are queued when an
// operation is accepted and checked when its result appears.
module tb_rca_chunked_adder;

  localparam int W = 64;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // per-instance signals
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [W-1:0] a         [3];
  logic [W-1:0] b         [3];
  logic         cin       [3];
  logic         sub       [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [W-1:0] sum       [3];
  logic         cout      [3];
  logic         ovf       [3];
  logic         busy      [3];
  logic [1:0]   dbg_state [3];

  rca_chunked_adder #(.WIDTH(64), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .sub(sub[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(sum[0]),
    .cout(cout[0]), .ovf(ovf[0]), .busy(busy[0]), .dbg_state(dbg_state[0]));

  rca_chunked_adder #(.WIDTH(64), .CHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .cin(cin[1]), .sub(sub[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(sum[1]),
    .cout(cout[1]), .ovf(ovf[1]), .busy(busy[1]), .dbg_state(dbg_state[1]));

  rca_chunked_adder #(.WIDTH(64), .CHUNK(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .cin(cin[2]), .sub(sub[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(sum[2]),
    .cout(cout[2]), .ovf(ovf[2]), .busy(busy[2]), .dbg_state(dbg_state[2]));

  // scoreboard: entries are {ovf, cout, sum}
  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_exp;
  int compared;
  int mismatched;

  task automatic check(input string tag, input logic [W+1:0] obs, input logic [W+1:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: plain integer arithmetic on 65-bit extensions.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
    logic [W:0]   u;
    logic [W:0]   sg;
    logic [W-1:0] r;
    logic         co;
    if (s) begin
      r  = x - y;
      co = (x >= y);
      sg = {x[W-1], x} - {y[W-1], y};
    end else begin
      u  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      r  = u[W-1:0];
      co = u[W];
      sg = {x[W-1], x} + {y[W-1], y} + {{W{1'b0}}, c};
    end
    return {sg[W] ^ sg[W-1], co, r};
  endfunction

  // driver: present one operation and let it be accepted on the next edge
  task automatic start(input int d, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic s, input logic [W+1:0] expv);
    check("in_ready_before_accept", {65'd0, in_ready[d]}, 66'd1);
    a[d] = x; b[d] = y; cin[d] = c; sub[d] = s; in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    exp_q.push_back(expv);
  endtask

  // wait for out_valid, checking the latency from the accept edge and the result
  task automatic wait_valid(input int d, input int lat, input string tag);
    int n;
    n = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (out_valid[d]) break;
    end
    check({tag, "_latency"}, 66'(n), 66'(lat));
    last_exp = exp_q.pop_front();
    check(tag, {ovf[d], cout[d], sum[d]}, last_exp);
  endtask

  task automatic release_out(input int d);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    check("back_to_idle", {64'd0, in_ready[d], out_valid[d]}, 66'b10);
  endtask

  task automatic op(input int d, input int lat, input string tag, input logic [W-1:0] x,
                    input logic [W-1:0] y, input logic c, input logic s, input logic [W+1:0] expv);
    start(d, x, y, c, s, expv);
    wait_valid(d, lat, tag);
    release_out(d);
  endtask

  initial begin
    logic [W-1:0] rx, ry;
    logic         rc, rs;
    int           seen;
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; a[i] = '0; b[i] = '0; cin[i] = 1'b0; sub[i] = 1'b0;
      out_ready[i] = 1'b0;
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_ctrl", {63'd0, in_ready[i], out_valid[i], busy[i]}, 66'b100);
      check("reset_data", {ovf[i], cout[i], sum[i]}, 66'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // directed cases, CHUNK=16
    op(0, 4, "add_10_35", 64'd10, 64'd35, 1'b0, 1'b0, {2'b00, 64'd45});
    op(0, 4, "add_cin", 64'd866945, 64'd3324752, 1'b1, 1'b0, {2'b00, 64'd4191698});
    op(0, 4, "full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, {2'b01, 64'd0});
    op(0, 4, "big_add", 64'd6223372036854775808, 64'd38701384792384, 1'b1, 1'b0,
       {2'b00, 64'd6223410738239568193});
    op(0, 4, "sub_neg", 64'd3846, 64'd9654, 1'b1, 1'b1, {2'b00, 64'hFFFF_FFFF_FFFF_E950});
    op(0, 4, "sub_pos", 64'd9654, 64'd3846, 1'b0, 1'b1, {2'b01, 64'd5808});
    op(0, 4, "ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
       {2'b10, 64'h8000_0000_0000_0000});
    op(0, 4, "ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
       {2'b11, 64'h7FFF_FFFF_FFFF_FFFF});

    // backpressure: result held while new operands are offered
    start(0, 64'd1000, 64'd234, 1'b0, 1'b0, model(64'd1000, 64'd234, 1'b0, 1'b0));
    wait_valid(0, 4, "bp_first");
    rx = {$urandom, $urandom};
    ry = {$urandom, $urandom};
    a[0] = rx; b[0] = ry; cin[0] = 1'b0; sub[0] = 1'b0; in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_data", {ovf[0], cout[0], sum[0]}, last_exp);
      check("bp_hold_ctrl", {63'd0, out_valid[0], in_ready[0], busy[0]}, 66'b101);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check("bp_idle", {63'd0, out_valid[0], in_ready[0], busy[0]}, 66'b010);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("bp_accepted", {63'd0, out_valid[0], in_ready[0], busy[0]}, 66'b001);
    exp_q.push_back(model(rx, ry, 1'b0, 1'b0));
    wait_valid(0, 4, "bp_second");
    release_out(0);

    // reset in the middle of RUN, after chunk 2
    start(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b0, 1'b0, 66'd0);
    void'(exp_q.pop_back());
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrun_rst_ctrl", {63'd0, in_ready[0], out_valid[0], busy[0]}, 66'b100);
    check("midrun_rst_data", {ovf[0], cout[0], sum[0]}, 66'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen++;
    end
    check("midrun_no_output", 66'(seen), 66'd0);
    op(0, 4, "after_rst_10_35", 64'd10, 64'd35, 1'b0, 1'b0, {2'b00, 64'd45});

    // randomized, CHUNK=16
    for (int i = 0; i < 20; i++) begin
      rx = {$urandom, $urandom};
      ry = (i % 4 == 0) ? ~rx : {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      op(0, 4, "rand16", rx, ry, rc, rs, model(rx, ry, rc, rs));
    end

    // CHUNK=1 and CHUNK=64
    op(1, 64, "c1_add_10_35", 64'd10, 64'd35, 1'b0, 1'b0, {2'b00, 64'd45});
    op(2, 1, "c64_add_10_35", 64'd10, 64'd35, 1'b0, 1'b0, {2'b00, 64'd45});
    op(1, 64, "c1_full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, {2'b01, 64'd0});
    op(2, 1, "c64_ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
       {2'b11, 64'h7FFF_FFFF_FFFF_FFFF});
    for (int i = 0; i < 4; i++) begin
      rx = {$urandom, $urandom};
      ry = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      op(1, 64, "rand1", rx, ry, rc, rs, model(rx, ry, rc, rs));
      op(2, 1, "rand64", rx, ry, rc, rs, model(rx, ry, rc, rs));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
